// File: rtl/cache_policy_arbiter_if.sv
// Bus bundle between miss requesters, the policy arbiter and the replacement-policy controller.
interface cache_policy_arbiter_if #(
  parameter int unsigned N_REQ             = 4,
  parameter int unsigned BW_REQ            = 2,
  parameter int unsigned BW_CACHE_CAPACITY = 8
);
  logic [N_REQ-1:0]             req_i;
  logic [N_REQ-1:0]             ack_o;
  logic [BW_CACHE_CAPACITY-1:0] addr_o;
  logic [BW_REQ-1:0]            grant_id_o;
  logic                         busy_o;
  logic                         err_o;
  logic                         pol_miss_o;
  logic                         pol_done_i;
  logic [BW_CACHE_CAPACITY-1:0] pol_addr_i;

  // Arbiter side.
  modport slave (
    input  req_i, pol_done_i, pol_addr_i,
    output ack_o, addr_o, grant_id_o, busy_o, err_o, pol_miss_o
  );

  // Requester / policy-controller side.
  modport master (
    output req_i, pol_done_i, pol_addr_i,
    input  ack_o, addr_o, grant_id_o, busy_o, err_o, pol_miss_o
  );
endinterface

// File: rtl/cache_policy_arbiter.sv
// Round-robin arbiter sharing one replacement-policy controller among N_REQ miss requesters.
// Define POLICY_ARB_TIMEOUT_EN to add a WAIT-state watchdog that reports err_o on expiry.
module cache_policy_arbiter #(
  parameter int unsigned N_REQ                = 4,
  parameter int unsigned BW_REQ               = 2,
  parameter int unsigned CACHE_BLOCK_CAPACITY = 256,
  parameter int unsigned BW_CACHE_CAPACITY    = 8,
  parameter int unsigned TIMEOUT_CYCLES       = 16
) (
  input logic                   clock_i,
  input logic                   resetn_i,
  cache_policy_arbiter_if.slave bus
);

  if (N_REQ < 2) begin : g_bad_nreq
    $error("N_REQ must be at least 2");
  end
  if (BW_CACHE_CAPACITY != $clog2(CACHE_BLOCK_CAPACITY)) begin : g_bad_bw
    $error("BW_CACHE_CAPACITY must equal clog2(CACHE_BLOCK_CAPACITY)");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                       state_q, state_d;
  logic [BW_REQ-1:0]            rr_q, rr_d;
  logic [BW_REQ-1:0]            grant_q, grant_d;
  logic [N_REQ-1:0]             ack_q, ack_d;
  logic [BW_CACHE_CAPACITY-1:0] addr_q, addr_d;
  logic                         miss_q, miss_d;
  logic                         busy_q, busy_d;
  logic [BW_REQ-1:0]            pick;
  logic                         found;
  int unsigned                  idx;

`ifdef POLICY_ARB_TIMEOUT_EN
  localparam int unsigned BwWd = $clog2(TIMEOUT_CYCLES + 1);
  logic            err_q, err_d;
  logic [BwWd-1:0] wd_q, wd_d;
`endif

  // First requester at or after rr_q, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = (32'(rr_q) + i) % N_REQ;
      if (!found && bus.req_i[BW_REQ'(idx)]) begin
        found = 1'b1;
        pick  = BW_REQ'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    ack_d   = '0;
    addr_d  = addr_q;
    miss_d  = 1'b0;
`ifdef POLICY_ARB_TIMEOUT_EN
    err_d   = err_q;
    wd_d    = wd_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d = pick;
          miss_d  = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
`ifdef POLICY_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      StWait: begin
        // Done wins over a watchdog expiry on the same cycle.
        if (bus.pol_done_i) begin
          addr_d  = bus.pol_addr_i;
          ack_d   = N_REQ'(1) << grant_q;
          state_d = StResp;
`ifdef POLICY_ARB_TIMEOUT_EN
          err_d   = 1'b0;
        end else if (wd_q == BwWd'(TIMEOUT_CYCLES - 1)) begin
          addr_d  = '0;
          err_d   = 1'b1;
          ack_d   = N_REQ'(1) << grant_q;
          state_d = StResp;
        end else begin
          wd_d    = wd_q + 1'b1;
`endif
        end
      end
      StResp: begin
        rr_d    = (grant_q == BW_REQ'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
      rr_q    <= '0;
      grant_q <= '0;
      ack_q   <= '0;
      addr_q  <= '0;
      miss_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef POLICY_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      miss_q  <= miss_d;
      busy_q  <= busy_d;
`ifdef POLICY_ARB_TIMEOUT_EN
      err_q   <= err_d;
      wd_q    <= wd_d;
`endif
    end
  end

  assign bus.ack_o      = ack_q;
  assign bus.addr_o     = addr_q;
  assign bus.grant_id_o = grant_q;
  assign bus.busy_o     = busy_q;
  assign bus.pol_miss_o = miss_q;
`ifdef POLICY_ARB_TIMEOUT_EN
  assign bus.err_o      = err_q;
`else
  assign bus.err_o      = 1'b0;
`endif

endmodule

// File: tb/tb_cache_policy_arbiter.sv
// Self-checking bench for cache_policy_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level round-robin model.
module tb_cache_policy_arbiter;

  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rr    = 0;
  int   w;

  always #5 clk = ~clk;

  cache_policy_arbiter_if #(.N_REQ(4), .BW_REQ(2), .BW_CACHE_CAPACITY(8)) bus ();

  cache_policy_arbiter #(
    .N_REQ               (4),
    .BW_REQ              (2),
    .CACHE_BLOCK_CAPACITY(256),
    .BW_CACHE_CAPACITY   (8),
    .TIMEOUT_CYCLES      (16)
  ) dut (
    .clock_i (clk),
    .resetn_i(rstn),
    .bus     (bus.slave)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner is the first pending requester at or after the pointer, wrapping.
  function automatic int model_pick(input logic [3:0] r, input int p);
    int k;
    for (int i = 0; i < 4; i++) begin
      k = (p + i) % 4;
      if (r[k[1:0]]) return k;
    end
    return 0;
  endfunction

  // One policy transaction: waits for the miss pulse, answers after `delay` WAIT cycles,
  // checks the ack, then updates the requester vector and the model pointer.
  task automatic do_txn(input int delay, input bit hold, input logic [7:0] addr,
                        input bit clr, input logic [3:0] set_mask, output int waited);
    int         exp;
    logic [3:0] oh;
    waited = 0;
    while (!bus.pol_miss_o && waited < 8) begin
      tick();
      waited++;
    end
    chk("miss_seen", 32'(bus.pol_miss_o), 32'd1);
    if (!bus.pol_miss_o) return;
    exp = model_pick(bus.req_i, rr);
    oh  = 4'b0001 << exp;
    chk("grant_id", 32'(bus.grant_id_o), 32'(exp));
    chk("busy_issue", 32'(bus.busy_o), 32'd1);
    // Stale done and junk address during ISSUE must not be captured.
    bus.pol_addr_i = ~addr;
    bus.pol_done_i = hold | 1'($urandom);
    for (int j = 1; j <= delay; j++) begin
      tick();
      chk("wait_ack", 32'(bus.ack_o), 32'd0);
      chk("wait_miss", 32'(bus.pol_miss_o), 32'd0);
      if (j == 1 && $urandom_range(3) == 0) bus.req_i = bus.req_i & ~oh;
      bus.pol_addr_i = addr;
      bus.pol_done_i = hold || (j == delay);
    end
    tick();
    chk("ack", 32'(bus.ack_o), 32'(oh));
    chk("addr", 32'(bus.addr_o), 32'(addr));
    chk("err", 32'(bus.err_o), 32'd0);
    chk("busy_resp", 32'(bus.busy_o), 32'd1);
    if (!hold) bus.pol_done_i = 1'b0;
    rr = (exp + 1) % 4;
    bus.req_i = (clr ? (bus.req_i & ~oh) : bus.req_i) | set_mask;
  endtask

  initial begin
    rstn           = 1'b0;
    bus.req_i      = 4'b1111;
    bus.pol_done_i = 1'b0;
    bus.pol_addr_i = 8'h00;
    tick();
    tick();
    chk("rst_ack", 32'(bus.ack_o), 32'd0);
    chk("rst_addr", 32'(bus.addr_o), 32'd0);
    chk("rst_grant", 32'(bus.grant_id_o), 32'd0);
    chk("rst_busy", 32'(bus.busy_o), 32'd0);
    chk("rst_err", 32'(bus.err_o), 32'd0);
    chk("rst_miss", 32'(bus.pol_miss_o), 32'd0);
    rstn = 1'b1;

    // All four held from reset: served 0,1,2,3 with addresses 0..3.
    rr = 0;
    for (int i = 0; i < 4; i++) do_txn(1, 1'b0, 8'(i), 1'b1, 4'b0000, w);
    tick();
    chk("idle_busy", 32'(bus.busy_o), 32'd0);
    chk("idle_ack", 32'(bus.ack_o), 32'd0);

    // Single request on requester 1.
    bus.req_i = 4'b0010;
    do_txn(1, 1'b0, 8'h05, 1'b1, 4'b0000, w);
    chk("single_issue_lat", 32'(w), 32'd1);
    tick();
    chk("addr_hold", 32'(bus.addr_o), 32'h05);

    // Fairness: requester 0 held, requester 2 joins after the first grant.
    bus.req_i = 4'b0001;
    do_txn(1, 1'b0, 8'h11, 1'b0, 4'b0100, w);
    do_txn(2, 1'b0, 8'h22, 1'b1, 4'b0000, w);
    chk("fair_grant2_done", 32'(rr), 32'd3);
    do_txn(1, 1'b0, 8'h33, 1'b1, 4'b0000, w);

    // Held done level across several transactions.
    bus.req_i = 4'b1011;
    for (int i = 0; i < 3; i++) do_txn(1, 1'b1, 8'($urandom), 1'b1, 4'b0000, w);
    bus.pol_done_i = 1'b0;

    // Reset mid-WAIT aborts without an ack; requester 2 re-served afterwards.
    tick();
    bus.req_i = 4'b0100;
    w = 0;
    while (!bus.pol_miss_o && w < 8) begin
      tick();
      w++;
    end
    chk("rw_miss", 32'(bus.pol_miss_o), 32'd1);
    tick();
    rstn = 1'b0;
    tick();
    chk("rw_ack", 32'(bus.ack_o), 32'd0);
    chk("rw_busy", 32'(bus.busy_o), 32'd0);
    chk("rw_miss0", 32'(bus.pol_miss_o), 32'd0);
    tick();
    chk("rw_ack2", 32'(bus.ack_o), 32'd0);
    rstn = 1'b1;
    rr   = 0;
    do_txn(1, 1'b0, 8'h3c, 1'b1, 4'b0000, w);

`ifdef POLICY_ARB_TIMEOUT_EN
    // Stuck done: ack after 16 WAIT cycles with err set and address zeroed.
    bus.req_i = 4'b0001;
    w = 0;
    while (!bus.pol_miss_o && w < 8) begin
      tick();
      w++;
    end
    w = 0;
    while (bus.ack_o == 4'b0000 && w < 40) begin
      tick();
      w++;
    end
    chk("to_lat", 32'(w), 32'd17);
    chk("to_err", 32'(bus.err_o), 32'd1);
    chk("to_addr", 32'(bus.addr_o), 32'd0);
    rr        = 1;
    bus.req_i = 4'b0000;
    tick();
    // Done on the 16th WAIT cycle beats the timeout.
    bus.req_i = 4'b0001;
    do_txn(16, 1'b0, 8'h99, 1'b1, 4'b0000, w);
`endif

    // Randomized transactions.
    bus.req_i = 4'($urandom_range(15, 1));
    for (int i = 0; i < 40; i++) begin
      bit hold;
      hold = ($urandom_range(3) == 0);
      do_txn(hold ? 1 : int'($urandom_range(4, 1)), hold, 8'($urandom),
             ($urandom_range(3) != 0), 4'($urandom), w);
      if (bus.req_i == 4'b0000) bus.req_i = 4'b0001 << $urandom_range(3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_policy_arbiter.md
Name: cache_policy_arbiter

Overview:
- Round-robin arbiter that shares one replacement-policy controller among N_REQ miss requesters, for example the I-side and D-side cache stages or multiple cache banks.
- Accepts level-held miss requests and sequences exactly one policy transaction at a time: pulse the policy's miss input, wait for its done, capture its replacement address.
- Returns the captured address to the granted requester with a one-cycle ack.

Parameters:
- N_REQ, 4, number of requesters; must be at least 2.
- BW_REQ, 2, requester index width; equals CLOG2(N_REQ).
- CACHE_BLOCK_CAPACITY, 256, block capacity of the cache that the policy controller manages.
- BW_CACHE_CAPACITY, 8, replacement address width; equals CLOG2(CACHE_BLOCK_CAPACITY).
- TIMEOUT_CYCLES, 16, watchdog limit; used only when POLICY_ARB_TIMEOUT_EN is defined.

Ports:
- clock_i, input, 1, single clock; all logic on its rising edge.
- resetn_i, input, 1, synchronous active-low reset.
- req_i, input, N_REQ, per-requester miss request; level, held until the matching ack.
- ack_o, output, N_REQ, one-hot one-cycle pulse to the served requester.
- addr_o, output, BW_CACHE_CAPACITY, replacement address; valid while any ack_o bit is high.
- grant_id_o, output, BW_REQ, index of the requester currently being served.
- busy_o, output, 1, high in every state except IDLE.
- err_o, output, 1, timeout flag; qualified by ack_o.
- pol_miss_o, output, 1, one-cycle trigger to the policy controller.
- pol_done_i, input, 1, policy done; may be a pulse or held level.
- pol_addr_i, input, BW_CACHE_CAPACITY, policy replacement address; valid when pol_done_i is high.

Behaviour:
- Reset (resetn_i low at a clock edge):
  - State goes to IDLE.
  - ack_o=0, addr_o=0, grant_id_o=0, busy_o=0, err_o=0, pol_miss_o=0.
  - Round-robin pointer rr_ptr=0; watchdog counter=0.
- Reset mid-transaction aborts it: no ack is issued and no pol_miss_o is sent. A requester that still holds req_i is re-arbitrated after reset.
- All outputs are registered.
- State machine, IDLE -> ISSUE -> WAIT -> RESP -> IDLE:
  - IDLE: if req_i != 0, select the first set bit at or after rr_ptr, searching upward and wrapping modulo N_REQ. Latch that index into grant_id_o and go to ISSUE. If req_i == 0, stay in IDLE.
  - ISSUE: pol_miss_o=1 for exactly this one cycle, then go to WAIT.
  - WAIT: pol_miss_o=0. On the first cycle with pol_done_i=1, latch pol_addr_i into addr_o and go to RESP. pol_done_i is ignored in every other state. A done level still high from a previous transaction is not accepted in ISSUE.
  - RESP: ack_o[grant_id_o]=1 for this one cycle; set rr_ptr = grant_id_o+1 mod N_REQ; go to IDLE.
- Minimum service time is 4 cycles from req_i sampled high to ack_o high, assuming pol_done_i is returned on the cycle after pol_miss_o. Maximum throughput is one service per 4 cycles.
- Requesters must drop req_i on the cycle after they see ack_o. A req_i still high in IDLE counts as a new miss.
- If a requester drops req_i mid-transaction, the transaction still completes: the policy address is consumed and the ack still pulses.
- New requests arriving while busy_o=1 wait; there is no queueing beyond the level req_i.
- rr_ptr wraps from N_REQ-1 to 0.
- Simultaneous requests are resolved by rr_ptr order only. A continuously asserted requester waits at most N_REQ-1 services.
- addr_o and err_o hold their values after RESP until the next capture.

Optional Feature:
- Macro: POLICY_ARB_TIMEOUT_EN.
- Defined:
  - The watchdog counts WAIT cycles.
  - When the count reaches TIMEOUT_CYCLES without pol_done_i, go to RESP with addr_o=0 and err_o=1.
  - The counter clears on entry to WAIT.
  - err_o=0 on normal completion.
  - If pol_done_i arrives on the same cycle as the timeout, the done wins: addr captured, err_o=0.
- Not defined: WAIT holds indefinitely, err_o is tied to 0, and no counter logic is generated.

Test Plan:
- Single request: req_i=4'b0010, policy returns done one cycle after miss with addr 8'h05 -> exactly one pol_miss_o pulse; ack_o=4'b0010 four cycles after request; addr_o=8'h05; grant_id_o=1.
- All four requesters held from reset (req_i=4'b1111), policy addresses 0,1,2,3 -> grants in order 0,1,2,3 with addr_o 0,1,2,3. Each requester drops req_i after its ack.
- Fairness: req_i[0] held continuously, req_i[2] asserted after the first grant -> the next grant is 2, then 0; requester 0 never starves requester 2.
- Held pol_done_i level: done stays 1 across transactions -> each WAIT captures on its first cycle; still one pol_miss_o pulse per ack.
- Reset mid-WAIT with req_i=4'b0100 held -> no ack during reset; after reset, rr_ptr=0 and requester 2 is served with a fresh pol_miss_o.
- POLICY_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pol_done_i stuck 0 -> ack after 16 WAIT cycles with err_o=1 and addr_o=0. A repeat run with done on cycle 16 gives err_o=0 and addr captured.
